// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional misalignment checking is enabled with `define DMEM_MISALIGN_CHECK_EN.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;

    // Word accesses must be 4-byte aligned, halfword accesses 2-byte aligned.
    function automatic logic is_misaligned(input logic [3:0] sel, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (sel == SEL_WORD) begin
            mis = (addr_lo != 2'b00);
        end else if ((sel == SEL_HALF_LO) || (sel == SEL_HALF_HI)) begin
            mis = addr_lo[0];
        end
        return mis;
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// MEM-stage data port between the pipeline (master) and the responder (slave).
//
// Handshake: the master raises mem_ce_i with we/addr/sel/data and holds all of
// them stable while stallreq_o is high. The slave completes the access with a
// single-cycle mem_ready_o pulse (and mem_err_o in the same cycle when the
// access was rejected as misaligned). Read data is valid from the ready cycle
// and holds until the next completed read. Dropping mem_ce_i before ready
// abandons the access without side effects.
interface dmem_resp_if;
    import dmem_resp_pkg::*;

    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        mem_err_o;
    logic        stallreq_o;
    dmem_state_e dbg_state;

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, mem_ready_o, mem_err_o, stallreq_o, dbg_state
    );

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, mem_ready_o, mem_err_o, stallreq_o, dbg_state
    );

endinterface

// File: rtl/dmem_resp_ram.sv
// Word-organised data RAM with per-byte write enables and a registered read
// port. The read register is the responder's read-data output, so it is the
// only part of the RAM that is reset.
module dmem_resp_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // Byte-lane write: lane i covers data[8i+7:8i].
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Read register loads only on a completing read and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one MEM-stage access at a time, inserts
// WAIT_CYCLES wait states, commits the write / loads read data on the edge
// entering DONE, and stalls the pipeline until completion.
// Optional: `define DMEM_MISALIGN_CHECK_EN rejects misaligned word/halfword
// accesses (no write, read data held) and flags them on mem_err_o.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    dmem_resp_if.slave  bus
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    dmem_state_e state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  sel_q;
    logic [31:0] data_q;
    logic        ready_q;
    logic        err_q;

    logic        fire;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [3:0]  acc_sel;
    logic [31:0] acc_data;
    logic        acc_mis;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic        unused_addr_bits;

    // Access being completed: live inputs when finishing straight from IDLE
    // (zero wait states), otherwise the copy captured at accept time.
    always_comb begin
        acc_we   = we_q;
        acc_addr = addr_q;
        acc_sel  = sel_q;
        acc_data = data_q;
        fire     = 1'b0;
        if (state_q == ST_IDLE) begin
            acc_we   = bus.mem_we_i;
            acc_addr = bus.mem_addr_i;
            acc_sel  = bus.mem_sel_i;
            acc_data = bus.mem_data_i;
        end
        if (!rst && bus.mem_ce_i) begin
            case (state_q)
                ST_IDLE: fire = (WAIT_CNT == 4'd0);
                ST_BUSY: fire = (cnt_q == 4'd1);
                default: fire = 1'b0;
            endcase
        end
`ifdef DMEM_MISALIGN_CHECK_EN
        acc_mis = is_misaligned(acc_sel, acc_addr[1:0]);
`else
        acc_mis = 1'b0;
`endif
        ram_we = (fire && acc_we && !acc_mis) ? acc_sel : 4'b0000;
        ram_re = fire && !acc_we && !acc_mis;
    end

    // Upper address bits alias; the byte offset only matters to the checker.
    assign unused_addr_bits = ^{acc_addr[31:ADDR_W+2], acc_addr[1:0]};

    // Access FSM with wait-state counter, capture registers and registered
    // ready/error pulses (high exactly during DONE).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            sel_q   <= 4'h0;
            data_q  <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.mem_ce_i) begin
                        we_q   <= bus.mem_we_i;
                        addr_q <= bus.mem_addr_i;
                        sel_q  <= bus.mem_sel_i;
                        data_q <= bus.mem_data_i;
                        cnt_q  <= WAIT_CNT;
                        if (WAIT_CNT == 4'd0) begin
                            state_q <= ST_DONE;
                            ready_q <= 1'b1;
                            err_q   <= acc_mis;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!bus.mem_ce_i) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= ST_DONE;
                            ready_q <= 1'b1;
                            err_q   <= acc_mis;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dmem_resp_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (acc_addr[ADDR_W+1:2]),
        .wdata_i (acc_data),
        .rdata_o (bus.mem_data_o)
    );

    assign bus.mem_ready_o = ready_q;
    assign bus.mem_err_o   = err_q;
    assign bus.stallreq_o  = bus.mem_ce_i & (state_q != ST_DONE);
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three responders (0, 1 and 3 wait states) share one
// stimulus bus; dsel picks which one sees mem_ce_i and whose outputs are
// observed. Expected read data is queued when an access is driven and
// checked when the responder signals ready.
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          dsel;

    logic [31:0] o_data;
    logic        o_ready;
    logic        o_err;
    logic        o_stall;
    dmem_state_e o_state;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd[4];
    logic [31:0] model[int];

    always #5 clk = ~clk;

    dmem_resp_if if0();
    dmem_resp_if if1();
    dmem_resp_if if3();

    assign if0.mem_ce_i = ce && (dsel == 0);
    assign if1.mem_ce_i = ce && (dsel == 1);
    assign if3.mem_ce_i = ce && (dsel == 3);
    assign if0.mem_we_i = we;    assign if1.mem_we_i = we;    assign if3.mem_we_i = we;
    assign if0.mem_addr_i = addr; assign if1.mem_addr_i = addr; assign if3.mem_addr_i = addr;
    assign if0.mem_sel_i = sel;  assign if1.mem_sel_i = sel;  assign if3.mem_sel_i = sel;
    assign if0.mem_data_i = wdata; assign if1.mem_data_i = wdata; assign if3.mem_data_i = wdata;

    dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    always_comb begin
        o_data  = if1.mem_data_o;
        o_ready = if1.mem_ready_o;
        o_err   = if1.mem_err_o;
        o_stall = if1.stallreq_o;
        o_state = if1.dbg_state;
        if (dsel == 0) begin
            o_data  = if0.mem_data_o;
            o_ready = if0.mem_ready_o;
            o_err   = if0.mem_err_o;
            o_stall = if0.stallreq_o;
            o_state = if0.dbg_state;
        end else if (dsel == 3) begin
            o_data  = if3.mem_data_o;
            o_ready = if3.mem_ready_o;
            o_err   = if3.mem_err_o;
            o_stall = if3.stallreq_o;
            o_state = if3.dbg_state;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic bench_mis(input logic [3:0] s, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (s == 4'b1111) return (a[1:0] != 2'b00);
        if ((s == 4'b0011) || (s == 4'b1100)) return a[0];
        return 1'b0;
`else
        return 1'b0 & (^{s, a});
`endif
    endfunction

    function automatic int mkey(input logic [31:0] a);
        return dsel * 65536 + int'(a[11:2]);
    endfunction

    function automatic logic [31:0] mdl(input logic [31:0] a);
        if (model.exists(mkey(a))) return model[mkey(a)];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] cur;
        cur = mdl(a);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
        end
        model[mkey(a)] = cur;
    endtask

    // One complete access on the selected responder; exp_rd is the data a
    // read must return (ignored for writes and rejected reads).
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [31:0] exp_rd, input int exp_stall);
        logic        mis;
        logic [31:0] want;
        int          stalls;
        bit          seen;
        mis    = bench_mis(s, a);
        stalls = 0;
        seen   = 1'b0;
        if (!w && !mis) last_rd[dsel] = exp_rd;
        exp_q.push_back(last_rd[dsel]);
        if (w && !mis) model_write(a, s, d);
        @(negedge clk);
        ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (o_ready) begin
                seen = 1'b1;
                ce   = 1'b0;
                want = exp_q.pop_front();
                check("rdata", o_data, want);
                check("err", 32'(o_err), 32'(mis));
            end else begin
                if (o_stall) stalls++;
                @(negedge clk);
            end
        end
        check("ready_seen", 32'(seen), 32'd1);
        if (!seen) begin
            ce = 1'b0;
            void'(exp_q.pop_front());
        end
        check("stall_len", 32'(stalls), 32'(exp_stall));
        @(negedge clk);
        #1;
        check("ready_pulse", 32'(o_ready), 32'd0);
    endtask

    // Start a full-word write of all ones, then abandon it in BUSY.
    task automatic abort_access(input bit by_rst, input logic [31:0] a);
        int rdy;
        rdy = 0;
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = a; sel = 4'hF; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        check("abort_busy", 32'(o_state), 32'(ST_BUSY));
        if (by_rst) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            ce  = 1'b0;
            for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
        end else begin
            ce = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (o_ready) rdy++;
        end
        check("abort_no_ready", 32'(rdy), 32'd0);
        check("abort_idle", 32'(o_state), 32'(ST_IDLE));
        if (by_rst) check("rst_data", o_data, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'h0; sel = 4'h0; wdata = 32'h0; dsel = 1;
        for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
        repeat (3) @(negedge clk);
        foreach (last_rd[d]) begin
            if (d != 2) begin
                dsel = d;
                #1;
                check("rst_data", o_data, 32'h0);
                check("rst_ready", 32'(o_ready), 32'd0);
                check("rst_err", 32'(o_err), 32'd0);
                check("rst_state", 32'(o_state), 32'(ST_IDLE));
            end
        end
        rst = 1'b0;

        // One wait state: full word, byte lane, empty sel, alias.
        dsel = 1;
        access(1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0, 2);
        access(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2);
        access(1'b1, 32'h10, 4'b0010, 32'h0000_AA00, 32'h0, 2);
        access(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAD_AAEF, 2);
        access(1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, 32'h0, 2);
        access(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAD_AAEF, 2);
        access(1'b1, 32'h1000, 4'b1111, 32'h1234_5678, 32'h0, 2);
        access(1'b0, 32'h0000, 4'b1111, 32'h0, 32'h1234_5678, 2);

        // Zero and three wait states.
        dsel = 0;
        access(1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D, 32'h0, 1);
        access(1'b0, 32'h20, 4'b1111, 32'h0, 32'hCAFE_F00D, 1);
        dsel = 3;
        access(1'b1, 32'h40, 4'b1111, 32'h0BAD_C0DE, 32'h0, 4);
        access(1'b0, 32'h40, 4'b1111, 32'h0, 32'h0BAD_C0DE, 4);

        // Abort by dropping ce, then by reset; the word must survive.
        abort_access(1'b0, 32'h40);
        access(1'b0, 32'h40, 4'b1111, 32'h0, 32'h0BAD_C0DE, 4);
        abort_access(1'b1, 32'h40);
        access(1'b0, 32'h40, 4'b1111, 32'h0, 32'h0BAD_C0DE, 4);

        // Alignment cases (rejected only when the check is built in).
        dsel = 1;
        access(1'b1, 32'h12, 4'b1111, 32'hFFFF_FFFF, 32'h0, 2);
        access(1'b0, 32'h10, 4'b1111, 32'h0, mdl(32'h10), 2);
        access(1'b1, 32'h12, 4'b1100, 32'h5566_0000, 32'h0, 2);
        access(1'b0, 32'h10, 4'b1111, 32'h0, mdl(32'h10), 2);
        access(1'b0, 32'h11, 4'b1111, 32'h0, mdl(32'h10), 2);
        access(1'b0, 32'h13, 4'b0011, 32'h0, mdl(32'h10), 2);

        // Random mix over a small pre-written window.
        for (int k = 0; k < 8; k++) begin
            access(1'b1, 32'h100 + 32'(4 * k), 4'b1111, $urandom, 32'h0, 2);
        end
        for (int k = 0; k < 24; k++) begin
            a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, mdl(a), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder at the far end of the MEM-stage memory port: mem_ce/we/addr/sel/data in, read data back.
- Holds a word-organised, byte-lane-writable data RAM and inserts a configurable number of wait states.
- Raises stallreq_o into stall_control until each access completes; the MEM stage is the initiator.

Parameters:
- ADDR_W, 10, word-address width; RAM holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 1, extra cycles between request accept and completion (0..15).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_ce_i  input  1  access request from MEM stage
- mem_we_i  input  1  1 = write, 0 = read
- mem_addr_i  input  32  byte address (`DataAddrBus)
- mem_sel_i  input  4  byte-lane enables; sel[i] covers data[8i+7:8i]
- mem_data_i  input  32  write data (`DataBus)
- mem_data_o  output  32  read data
- mem_ready_o  output  1  one-cycle completion pulse
- mem_err_o  output  1  misaligned-access flag (see Optional Feature)
- stallreq_o  output  1  pipeline stall request to stall_control

Behaviour:
- Interface: clk/rst only, one clock domain; reset synchronous active-high. On rst: state IDLE, counter 0, mem_data_o=0, mem_ready_o=0, mem_err_o=0. RAM contents are not reset.
- Word index = mem_addr_i[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias modulo 2^(ADDR_W+2).
- FSM states:
  - IDLE: if mem_ce_i=1, capture we/addr/sel/data, load counter=WAIT_CYCLES, go BUSY if WAIT_CYCLES>0, else DONE.
  - BUSY: decrement counter; at counter==1 go DONE. If mem_ce_i drops, abort to IDLE with no write.
  - DONE: mem_ready_o=1 for exactly this cycle, then IDLE unconditionally.
- Write commit: on the edge entering DONE, each lane with sel[i]=1 is written. sel=0000 completes the handshake but changes nothing.
- Read: on the edge entering DONE, mem_data_o is loaded with the full stored word. It holds until the next read completes; writes leave mem_data_o unchanged.
- stallreq_o (combinational) = mem_ce_i & (state != DONE).
- Latency: accept cycle + WAIT_CYCLES + DONE cycle. The stall lasts WAIT_CYCLES+1 cycles; with WAIT_CYCLES=0 the stall is one cycle.
- Initiator must hold ce/we/addr/sel/data stable while stallreq_o=1. The captured copy is used regardless.
- Back-to-back: a request present in DONE belongs to the finishing access. A new access is accepted only in IDLE, so at most one access per two cycles.
- rst mid-access: return to IDLE, no write, mem_ready_o=0 on the following cycle.
- Read-after-write to the same word: the second access sees the written data.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined: an access is misaligned when
  - sel=1111 and addr[1:0]!=0, or
  - sel is 0011 or 1100 and addr[0]!=0.
- A misaligned access runs the normal handshake, but its write is suppressed. mem_err_o pulses together with mem_ready_o, and mem_data_o is left unchanged on reads.
- Undefined: no check; mem_err_o tied 0; all accesses are committed per sel.

Decomposition:
- consts.vh: DMEM FSM state encodings (`DMEM_IDLE/`DMEM_BUSY/`DMEM_DONE, 2 bits), `DMEM_SEL_WORD/`DMEM_SEL_HALF_LO/`DMEM_SEL_HALF_HI. Existing `DataBus/`DataAddrBus are reused.
- Sub-module dmem_ram: synchronous 2^ADDR_W x 32 array with 4 byte write enables and registered read port. dmem_resp contains FSM, counter, capture registers and the misalign check.

Test Plan:
- Reset, then write addr=0x10 sel=1111 data=0xDEADBEEF, WAIT_CYCLES=1 -> stallreq_o high 2 cycles, mem_ready_o pulses once; a read of 0x10 then returns 0xDEADBEEF.
- Byte-lane write sel=0010 data=0x0000AA00 to 0x10 -> read returns 0xDEADAAEF; a sel=0000 write leaves it unchanged but still pulses ready.
- WAIT_CYCLES=0 read -> stallreq_o exactly 1 cycle, data valid in the ready cycle. WAIT_CYCLES=3 -> stall 4 cycles.
- Alias with ADDR_W=10: write 0x1000 data=0x12345678 -> read of 0x0000 returns 0x12345678.
- Abort and reset: mem_ce_i dropped in BUSY, or rst asserted in BUSY, during a write of 0xFFFFFFFF -> no ready pulse, the target word keeps its old value, FSM back in IDLE.
- With DMEM_MISALIGN_CHECK_EN: word write to 0x12 -> mem_err_o and mem_ready_o pulse together and memory is unchanged. Halfword sel=1100 at 0x12 -> no error, write committed.
